// File: rtl/hilo_unit_pkg.sv
// Shared HI/LO op codes and bus widths for the HI/LO register unit.
// Imported by hilo_unit and its bench.
package hilo_unit_pkg;

  localparam int HILO_OP_W      = 2;
  localparam int REG_BUS_W      = 32;
  localparam int DOUBLE_REG_BUS = 2 * REG_BUS_W;

  typedef enum logic [HILO_OP_W-1:0] {
    HILO_OP_NONE   = 2'b00,
    HILO_OP_MULDIV = 2'b01,
    HILO_OP_MTHI   = 2'b10,
    HILO_OP_MTLO   = 2'b11
  } hilo_op_e;

endpackage

// File: rtl/hilo_unit.sv
// Architectural HI/LO registers with a one-deep MEM-stage slot, so a write can
// still be discarded by an exception before it commits; MFHI/MFLO see the youngest value.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int DW   = REG_BUS_W,
  parameter int OP_W = HILO_OP_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [OP_W-1:0] ex_hilo_op,
  input  logic [2*DW-1:0] ex_muldiv_res,
  input  logic [DW-1:0]   ex_src1,
  input  logic            pipe_stall,
  input  logic            mem_flush,
  output logic [DW-1:0]   hi_o,
  output logic [DW-1:0]   lo_o,
  output logic [DW-1:0]   hi_arch,
  output logic [DW-1:0]   lo_arch,
  output logic            pend_o
);

  // Flow control: an EX write is taken on an edge only when ex_valid=1,
  // pipe_stall=0 and mem_flush=0; a stalled edge holds both the slot and
  // the architectural pair, so the upstream stage must keep its inputs stable.

  hilo_op_e      op;
  logic          m_valid_q, m_valid_d;
  logic          m_we_hi_q, m_we_hi_d;
  logic          m_we_lo_q, m_we_lo_d;
  logic [DW-1:0] m_hi_q, m_hi_d;
  logic [DW-1:0] m_lo_q, m_lo_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          commit;

  assign op = hilo_op_e'(ex_hilo_op[HILO_OP_W-1:0]);

  always_comb begin
    m_valid_d = m_valid_q;
    m_we_hi_d = m_we_hi_q;
    m_we_lo_d = m_we_lo_q;
    m_hi_d    = m_hi_q;
    m_lo_d    = m_lo_q;
    commit    = 1'b0;
    if (mem_flush) begin
      // Kills the slot before it can commit and drops the EX instruction.
      m_valid_d = 1'b0;
    end else if (!pipe_stall) begin
      commit    = m_valid_q;
      m_valid_d = 1'b0;
      m_we_hi_d = 1'b0;
      m_we_lo_d = 1'b0;
      if (ex_valid) begin
        case (op)
          HILO_OP_MULDIV: begin
            m_valid_d = 1'b1;
            m_we_hi_d = 1'b1;
            m_we_lo_d = 1'b1;
            m_hi_d    = ex_muldiv_res[2*DW-1:DW];
            m_lo_d    = ex_muldiv_res[DW-1:0];
          end
          HILO_OP_MTHI: begin
            m_valid_d = 1'b1;
            m_we_hi_d = 1'b1;
            m_hi_d    = ex_src1;
          end
          HILO_OP_MTLO: begin
            m_valid_d = 1'b1;
            m_we_lo_d = 1'b1;
            m_lo_d    = ex_src1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    hi_d = (commit && m_we_hi_q) ? m_hi_q : hi_q;
    lo_d = (commit && m_we_lo_q) ? m_lo_q : lo_q;
  end

  // MEM slot
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_we_hi_q <= 1'b0;
      m_we_lo_q <= 1'b0;
      m_hi_q    <= '0;
      m_lo_q    <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_we_hi_q <= m_we_hi_d;
      m_we_lo_q <= m_we_lo_d;
      m_hi_q    <= m_hi_d;
      m_lo_q    <= m_lo_d;
    end
  end

  // Architectural pair
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o    = (m_valid_q && m_we_hi_q) ? m_hi_q : hi_q;
  assign lo_o    = (m_valid_q && m_we_lo_q) ? m_lo_q : lo_q;
  assign hi_arch = hi_q;
  assign lo_arch = lo_q;
  assign pend_o  = m_valid_q;

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Holds the architectural HI/LO registers of the dual-issue MIPS core. It is the consumer of the EX-stage ALU's 64-bit mul/div result and of MTHI/MTLO operands.
- Stages every HI/LO write through a MEM-slot register and commits it one stage later, so an exception can still discard it (precise exceptions).
- Forwards the youngest pending value to MFHI/MFLO in EX.
- Only one HI/LO-writing instruction can be in a packet; issue logic guarantees this.

Parameters:
- DW, 32, width of HI and of LO.
- OP_W, 2, width of the hilo op code.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX carries a HI/LO-writing instruction; low while the divider is busy (stallreq_exe)
- ex_hilo_op  in  OP_W  00 NONE, 01 MULDIV (write both), 10 MTHI, 11 MTLO
- ex_muldiv_res  in  2*DW  {HI,LO}; for div this is {remainder,quotient}
- ex_src1  in  DW  operand for MTHI/MTLO
- pipe_stall  in  1  EX→MEM and MEM→commit both hold
- mem_flush  in  1  exception/eret in MEM; kills the MEM slot and the EX instruction
- hi_o  out  DW  forwarded HI for MFHI
- lo_o  out  DW  forwarded LO for MFLO
- hi_arch  out  DW  committed HI (debug/trace)
- lo_arch  out  DW  committed LO
- pend_o  out  1  MEM slot holds an uncommitted write

Behaviour:
- State: hi_q, lo_q (architectural); m_valid, m_we_hi, m_we_lo, m_hi, m_lo (MEM slot).
- Reset (synchronous, edge with reset=1):
  - All state cleared to 0.
  - Outputs therefore read 0: hi_o=lo_o=hi_arch=lo_arch=0, pend_o=0.
  - Reset overrides flush and stall.
- Per-edge priority: reset > mem_flush > pipe_stall > normal.
- mem_flush=1:
  - m_valid←0; no commit this edge.
  - The EX instruction is not captured.
  - hi_q/lo_q are unchanged.
- pipe_stall=1 (no flush): all state holds.
- Normal edge:
  1. Commit: if m_valid, then hi_q←m_hi when m_we_hi, and lo_q←m_lo when m_we_lo.
  2. Capture: m_valid ← ex_valid && op!=NONE.
     - MULDIV: we_hi=we_lo=1, m_hi=res[63:32], m_lo=res[31:0].
     - MTHI: we_hi=1, m_hi=ex_src1; m_lo holds its previous value.
     - MTLO: symmetric to MTHI.
- Commit latency: an EX write becomes architectural on the 2nd unstalled, unflushed edge after it appears in EX.
- Forwarding (combinational):
  - hi_o = (m_valid && m_we_hi) ? m_hi : hi_q; lo_o is symmetric.
  - Back-to-back MULT→MFHI therefore needs no stall.
- pend_o = m_valid.
- ex_valid with op=NONE is treated as no write.
- Write width is always full 32 bits; no sign handling here, because the ALU already produced the final value.
- A flush arriving in the same cycle that a slot would commit kills that write; the older architectural value is kept.

Decomposition:
- Shared defines header holds:
  - HILO_OP_NONE/MULDIV/MTHI/MTLO codes
  - HILO_OP_W
  - DOUBLE_REG_BUS width macro, reused from the existing defines
- No sub-module. A single file with one always block for the MEM slot and one for the architectural registers.

Test Plan:
- Reset: hold reset 2 cycles after random writes → hi_o=lo_o=hi_arch=lo_arch=0, pend_o=0.
- MULDIV res=64'hFFFF_FFFE_0000_0001 (mult −1×… pattern):
  - next cycle: hi_o=FFFFFFFE, lo_o=00000001, hi_arch unchanged, pend_o=1
  - cycle after: hi_arch=FFFFFFFE, lo_arch=00000001
- MTHI src1=12345678, then MTLO src1=9ABCDEF0 back-to-back:
  - hi_o=12345678 with lo_o still old while MTHI is pending
  - after MTLO is captured, both hi_o/lo_o show the new values
  - final arch = 12345678 / 9ABCDEF0
- MULDIV captured, then mem_flush=1 on the next edge → pend_o=0, hi_o/lo_o revert to prior arch values, never committed.
- pipe_stall held 3 cycles with a pending MTHI → pend_o stays 1, hi_arch unchanged, EX changes ignored; commits on the first edge after stall drops.
- Simultaneous pipe_stall=1 and mem_flush=1 with a pending slot → flush wins: slot cleared, arch unchanged.
